// File: rtl/pid_pkg.sv
// Shared constants, reset values and types for the multi-channel PID window classifier.
package pid_pkg;

    localparam logic [7:0]  REG_CFG = 8'h00;
    localparam logic [7:0]  REG_EW  = 8'h01;
    localparam logic [7:0]  REG_PW  = 8'h02;
    localparam logic [7:0]  REG_MW  = 8'h03;
    localparam logic [7:0]  CNT_BLK = 8'h40;

    localparam int EN_E    = 0;
    localparam int EN_P    = 1;
    localparam int EN_M    = 2;
    localparam int EXCL    = 3;
    localparam int STR_LSB = 4;
    localparam int STR_MSB = 7;
    localparam int CLR     = 8;

    localparam logic [7:0]  CFG_RST = 8'h07;
    localparam logic [31:0] EW_RST  = 32'hFFFF_FFFF;
    localparam logic [31:0] PW_RST  = 32'h0000_F000;
    localparam logic [31:0] MW_RST  = 32'h0F00_0000;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } str_state_e;

    // True when two or more of the three species flags are set.
    function automatic logic multi_hit(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/pid_chan.sv
// One classifier channel: local-bus registers, two-stage window match,
// pulse-stretch FSM with retrigger inhibit and saturating species counters.
module pid_chan
    import pid_pkg::*;
#(
    parameter int         CH     = 0,
    parameter int         SLICES = 32,
    parameter logic [7:0] BASE   = 8'h00,
    parameter int         CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n_i,
    input  logic [SLICES-1:0] hit_vec_i,
    input  logic              hit_valid_i,
    input  logic [31:0]       data_i,
    input  logic [7:0]        addr_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              electron_o,
    output logic              pion_o,
    output logic              muon_o,
    output logic              ambig_o,
    output logic [31:0]       data_o
);

    localparam logic [7:0] CH_OFF  = 8'(4 * CH);
    localparam logic [7:0] A_CFG   = BASE + CH_OFF + REG_CFG;
    localparam logic [7:0] A_EW    = BASE + CH_OFF + REG_EW;
    localparam logic [7:0] A_PW    = BASE + CH_OFF + REG_PW;
    localparam logic [7:0] A_MW    = BASE + CH_OFF + REG_MW;
    localparam logic [7:0] A_CNT_E = BASE + CNT_BLK + CH_OFF + 8'h00;
    localparam logic [7:0] A_CNT_P = BASE + CNT_BLK + CH_OFF + 8'h01;
    localparam logic [7:0] A_CNT_M = BASE + CNT_BLK + CH_OFF + 8'h02;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [7:0]        cfg_q;
    logic [SLICES-1:0] ew_q;
    logic [SLICES-1:0] pw_q;
    logic [SLICES-1:0] mw_q;
    logic [2:0]        match_s;
    logic [2:0]        m_q;
    logic [2:0]        cand_s;
    logic [2:0]        fire_s;
    logic [2:0]        out_q;
    logic              ambig_s;
    logic              ambig_q;
    logic [3:0]        stretch_s;
    logic [3:0]        str_cnt_q;
    str_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q [3];
    logic              wr_cfg_s;
    logic              wr_ew_s;
    logic              wr_pw_s;
    logic              wr_mw_s;
    logic              clr_s;
    logic [31:0]       rd_s;

    assign wr_cfg_s = write_i & (addr_i == A_CFG);
    assign wr_ew_s  = write_i & (addr_i == A_EW);
    assign wr_pw_s  = write_i & (addr_i == A_PW);
    assign wr_mw_s  = write_i & (addr_i == A_MW);
    // The clear bit is never stored, so it reads back as 0 by construction.
    assign clr_s    = wr_cfg_s & data_i[CLR];

    // Configuration and window registers.
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            cfg_q <= CFG_RST;
            ew_q  <= EW_RST[SLICES-1:0];
            pw_q  <= PW_RST[SLICES-1:0];
            mw_q  <= MW_RST[SLICES-1:0];
        end else begin
            cfg_q <= wr_cfg_s ? data_i[7:0] : cfg_q;
            ew_q  <= wr_ew_s ? data_i[SLICES-1:0] : ew_q;
            pw_q  <= wr_pw_s ? data_i[SLICES-1:0] : pw_q;
            mw_q  <= wr_mw_s ? data_i[SLICES-1:0] : mw_q;
        end
    end

    assign match_s[EN_E] = hit_valid_i & (|(hit_vec_i & ew_q));
    assign match_s[EN_P] = hit_valid_i & (|(hit_vec_i & pw_q));
    assign match_s[EN_M] = hit_valid_i & (|(hit_vec_i & mw_q));

    // Stage 1: registered per-species window match.
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            m_q <= 3'b000;
        end else begin
            m_q <= match_s;
        end
    end

    // Stage 2 qualification: enables, exclusive-mode ambiguity and HOLD inhibit.
    always_comb begin
        cand_s    = m_q & cfg_q[EN_M:EN_E];
        stretch_s = cfg_q[STR_MSB:STR_LSB];
        ambig_s   = 1'b0;
        fire_s    = 3'b000;
        if (state_q == IDLE) begin
            if (cfg_q[EXCL] && multi_hit(cand_s)) begin
                ambig_s = 1'b1;
            end else begin
                fire_s = cand_s;
            end
        end else begin
            ambig_s = 1'b0;
            fire_s  = 3'b000;
        end
    end

    // Stretch FSM; S=0 never enters HOLD so back-to-back hits give back-to-back pulses.
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            str_cnt_q <= 4'd0;
            out_q     <= 3'b000;
            ambig_q   <= 1'b0;
        end else begin
            ambig_q <= ambig_s;
            case (state_q)
                IDLE: begin
                    out_q     <= fire_s;
                    str_cnt_q <= stretch_s;
                    if ((fire_s != 3'b000) && (stretch_s != 4'd0)) begin
                        state_q <= HOLD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                HOLD: begin
                    if (str_cnt_q == 4'd0) begin
                        state_q <= IDLE;
                        out_q   <= 3'b000;
                    end else begin
                        state_q   <= HOLD;
                        str_cnt_q <= str_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    str_cnt_q <= 4'd0;
                    out_q     <= 3'b000;
                end
            endcase
        end
    end

    // Saturating per-species counters; a clear write beats a coinciding increment.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n_i || clr_s) begin
                cnt_q[k] <= CNT_ZERO;
            end else if (fire_s[k] && (cnt_q[k] != CNT_MAX)) begin
                cnt_q[k] <= cnt_q[k] + CNT_ONE;
            end else begin
                cnt_q[k] <= cnt_q[k];
            end
        end
    end

    // Read-back slice for this channel, zero when not addressed.
    always_comb begin
        rd_s = 32'h0000_0000;
        if (read_i) begin
            case (addr_i)
                A_CFG:   rd_s = {24'h00_0000, cfg_q};
                A_EW:    rd_s = 32'(ew_q);
                A_PW:    rd_s = 32'(pw_q);
                A_MW:    rd_s = 32'(mw_q);
                A_CNT_E: rd_s = 32'(cnt_q[0]);
                A_CNT_P: rd_s = 32'(cnt_q[1]);
                A_CNT_M: rd_s = 32'(cnt_q[2]);
                default: rd_s = 32'h0000_0000;
            endcase
        end else begin
            rd_s = 32'h0000_0000;
        end
    end

    assign electron_o = out_q[EN_E];
    assign pion_o     = out_q[EN_P];
    assign muon_o     = out_q[EN_M];
    assign ambig_o    = ambig_q;
    assign data_o     = rd_s;

endmodule

// File: rtl/pid_window_classifier.sv
// Multi-channel PID window classifier: NCH independent channels sharing one
// local bus whose read data is the OR of the per-channel slices.
module pid_window_classifier
    import pid_pkg::*;
#(
    parameter int         NCH    = 4,
    parameter int         SLICES = 32,
    parameter logic [7:0] BASE   = 8'h00,
    parameter int         CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH*SLICES-1:0] hit_vec,
    input  logic [NCH-1:0]        hit_valid,
    output logic [NCH-1:0]        Electron,
    output logic [NCH-1:0]        Pion,
    output logic [NCH-1:0]        Muon,
    output logic [NCH-1:0]        Ambig,
    input  logic [31:0]           DataIn,
    input  logic [7:0]            Address,
    input  logic                  Read,
    input  logic                  Write,
    output logic [31:0]           DataOut
);

    logic [31:0] chan_rd_s [NCH];
    logic [31:0] rd_or_s;

    for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
        pid_chan #(
            .CH     (ch),
            .SLICES (SLICES),
            .BASE   (BASE),
            .CNT_W  (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst_n_i     (rst),
            .hit_vec_i   (hit_vec[ch*SLICES +: SLICES]),
            .hit_valid_i (hit_valid[ch]),
            .data_i      (DataIn),
            .addr_i      (Address),
            .read_i      (Read),
            .write_i     (Write),
            .electron_o  (Electron[ch]),
            .pion_o      (Pion[ch]),
            .muon_o      (Muon[ch]),
            .ambig_o     (Ambig[ch]),
            .data_o      (chan_rd_s[ch])
        );
    end

    // OR-bus merge of the channel read slices.
    always_comb begin
        rd_or_s = 32'h0000_0000;
        for (int c = 0; c < NCH; c++) begin
            rd_or_s = rd_or_s | chan_rd_s[c];
        end
    end

    assign DataOut = rd_or_s;

endmodule

// File: tb/tb_pid_window_classifier.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// timeline-based reference model of the classifier.
module tb_pid_window_classifier;

    localparam int NCH     = 4;
    localparam int SLICES  = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_SAT = 15;

    logic                  clk;
    logic                  rst;
    logic [NCH*SLICES-1:0] hit_vec;
    logic [NCH-1:0]        hit_valid;
    logic [NCH-1:0]        Electron;
    logic [NCH-1:0]        Pion;
    logic [NCH-1:0]        Muon;
    logic [NCH-1:0]        Ambig;
    logic [31:0]           DataIn;
    logic [31:0]           DataOut;
    logic [7:0]            Address;
    logic                  Read;
    logic                  Write;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: registers, counters and per-channel pulse timeline.
    logic [7:0]  m_cfg      [NCH];
    logic [31:0] m_win      [NCH][3];
    int          m_cnt      [NCH][3];
    logic [2:0]  m_pend     [NCH];
    logic [2:0]  m_latch    [NCH];
    int          m_out_end  [NCH];
    int          m_hold_end [NCH];
    logic [2:0]  exp_out    [NCH];
    logic        exp_amb    [NCH];
    int          edge_no = 0;

    pid_window_classifier #(
        .NCH    (NCH),
        .SLICES (SLICES),
        .BASE   (8'h00),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hit_vec   (hit_vec),
        .hit_valid (hit_valid),
        .Electron  (Electron),
        .Pion      (Pion),
        .Muon      (Muon),
        .Ambig     (Ambig),
        .DataIn    (DataIn),
        .Address   (Address),
        .Read      (Read),
        .Write     (Write),
        .DataOut   (DataOut)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cfg[c]      = 8'h07;
            m_win[c][0]   = 32'hFFFF_FFFF;
            m_win[c][1]   = 32'h0000_F000;
            m_win[c][2]   = 32'h0F00_0000;
            m_pend[c]     = 3'b000;
            m_latch[c]    = 3'b000;
            m_out_end[c]  = -100;
            m_hold_end[c] = -100;
            exp_out[c]    = 3'b000;
            exp_amb[c]    = 1'b0;
            for (int k = 0; k < 3; k++) m_cnt[c][k] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic [2:0]  cand;
        logic [31:0] slice;
        int          s;
        int          a;
        edge_no++;
        if (!rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            cand       = m_pend[c] & m_cfg[c][2:0];
            s          = int'(m_cfg[c][7:4]);
            exp_amb[c] = 1'b0;
            if (edge_no <= m_hold_end[c]) begin
                exp_out[c] = (edge_no <= m_out_end[c]) ? m_latch[c] : 3'b000;
            end else if (m_cfg[c][3] && ($countones(cand) >= 2)) begin
                exp_amb[c] = 1'b1;
                exp_out[c] = 3'b000;
            end else begin
                exp_out[c] = cand;
                if (cand != 3'b000) begin
                    m_latch[c]    = cand;
                    m_out_end[c]  = edge_no + s;
                    m_hold_end[c] = (s > 0) ? edge_no + s + 1 : edge_no;
                    for (int k = 0; k < 3; k++)
                        if (cand[k] && m_cnt[c][k] < CNT_SAT) m_cnt[c][k]++;
                end
            end
            slice = hit_vec[c*SLICES +: SLICES];
            for (int k = 0; k < 3; k++)
                m_pend[c][k] = hit_valid[c] && ((slice & m_win[c][k]) != 32'h0);
        end
        if (Write) begin
            a = int'(Address);
            for (int c = 0; c < NCH; c++) begin
                if (a == 4*c) begin
                    m_cfg[c] = DataIn[7:0];
                    if (DataIn[8]) for (int k = 0; k < 3; k++) m_cnt[c][k] = 0;
                end else if (a >= 4*c + 1 && a <= 4*c + 3) begin
                    m_win[c][a - 4*c - 1] = DataIn;
                end
            end
        end
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] addr);
        int a;
        a = int'(addr);
        for (int c = 0; c < NCH; c++) begin
            if (a == 4*c) return {24'h00_0000, m_cfg[c]};
            if (a >= 4*c + 1 && a <= 4*c + 3) return m_win[c][a - 4*c - 1];
            for (int k = 0; k < 3; k++)
                if (a == 64 + 4*c + k) return 32'(m_cnt[c][k]);
        end
        return 32'h0;
    endfunction

    // One clock: update the model at the rising edge, compare outputs on the falling edge.
    task automatic tick();
        logic [3:0] ee, pe, me, ae;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            ee[c] = exp_out[c][0];
            pe[c] = exp_out[c][1];
            me[c] = exp_out[c][2];
            ae[c] = exp_amb[c];
        end
        check_val("electron", 32'(Electron), 32'(ee));
        check_val("pion",     32'(Pion),     32'(pe));
        check_val("muon",     32'(Muon),     32'(me));
        check_val("ambig",    32'(Ambig),    32'(ae));
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        Address = a;
        DataIn  = d;
        Write   = 1'b1;
        tick();
        Write   = 1'b0;
        DataIn  = 32'h0;
        Address = 8'h00;
    endtask

    task automatic bus_read_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        Address = a;
        Read    = 1'b1;
        #1;
        check_val(tag, DataOut, exp);
        Read    = 1'b0;
        Address = 8'h00;
        tick();
    endtask

    task automatic set_hit(input int c, input logic [31:0] v);
        hit_vec[c*SLICES +: SLICES] = v;
        hit_valid[c] = 1'b1;
    endtask

    task automatic clear_hits();
        hit_vec   = '0;
        hit_valid = '0;
    endtask

    initial begin
        logic [6:0]  str_exp;
        logic [4:0]  b2b_exp;
        logic [31:0] r;
        logic [31:0] snap [3][3];
        int          ch;

        rst = 1'b0;
        hit_vec = '0;
        hit_valid = '0;
        DataIn = 32'h0;
        Address = 8'h00;
        Read = 1'b0;
        Write = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b1;

        // Reset defaults and bus idle value
        #1;
        check_val("bus_idle", DataOut, 32'h0);
        bus_read_chk("rst_cfg0", 8'h00, 32'h0000_0007);
        bus_read_chk("rst_ew0",  8'h01, 32'hFFFF_FFFF);
        bus_read_chk("rst_pw0",  8'h02, 32'h0000_F000);
        bus_read_chk("rst_mw3",  8'h0F, 32'h0F00_0000);
        bus_read_chk("rst_cnt",  8'h41, 32'h0);
        bus_read_chk("cnt_pad",  8'h43, 32'h0);
        bus_read_chk("unmapped", 8'h80, 32'h0);

        // Default windows: slice 13 is both electron and pion
        set_hit(0, 32'h0000_2000);
        tick();
        clear_hits();
        tick();
        check_val("def_e", 32'(Electron[0]), 32'h1);
        check_val("def_p", 32'(Pion[0]),     32'h1);
        check_val("def_m", 32'(Muon[0]),     32'h0);
        tick();
        check_val("def_e_drop", 32'(Electron[0]), 32'h0);
        bus_read_chk("def_cnt_e", 8'h40, 32'h1);

        // Exclusive mode on ch1
        bus_write(8'h04, 32'h0000_000F);
        set_hit(1, 32'h0000_2000);
        tick();
        clear_hits();
        tick();
        check_val("excl_amb", 32'(Ambig[1]),    32'h1);
        check_val("excl_e",   32'(Electron[1]), 32'h0);
        check_val("excl_p",   32'(Pion[1]),     32'h0);
        tick();
        check_val("excl_amb_drop", 32'(Ambig[1]), 32'h0);
        bus_read_chk("excl_cnt_e", 8'h44, 32'h0);
        bus_read_chk("excl_cnt_p", 8'h45, 32'h0);
        bus_write(8'h05, 32'h0);
        set_hit(1, 32'h0400_0000);
        tick();
        clear_hits();
        tick();
        check_val("excl_mu", 32'(Muon[1]), 32'h1);
        tick();
        bus_read_chk("excl_cnt_m", 8'h46, 32'h1);

        // Stretch S=3 with retrigger inhibit on ch0
        bus_write(8'h00, 32'h0000_0137);
        bus_write(8'h01, 32'h0000_0001);
        str_exp = 7'b0011110;
        for (int i = 0; i < 7; i++) begin
            if (i == 0 || i == 2) set_hit(0, 32'h1);
            else clear_hits();
            tick();
            check_val("stretch_e", 32'(Electron[0]), 32'(str_exp[i]));
        end
        bus_read_chk("stretch_cnt", 8'h40, 32'h1);

        // S=0: back-to-back hits give back-to-back pulses
        bus_write(8'h00, 32'h0000_0107);
        b2b_exp = 5'b01110;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) set_hit(0, 32'h1);
            else clear_hits();
            tick();
            check_val("b2b_e", 32'(Electron[0]), 32'(b2b_exp[i]));
        end
        bus_read_chk("b2b_cnt", 8'h40, 32'h3);

        // Saturation and clear
        for (int i = 0; i < 20; i++) begin
            set_hit(0, 32'h1);
            tick();
            clear_hits();
            tick();
        end
        tick();
        tick();
        bus_read_chk("sat_cnt", 8'h40, 32'd15);
        bus_write(8'h00, 32'h0000_0107);
        bus_read_chk("clr_cnt", 8'h40, 32'h0);
        bus_read_chk("clr_cfg", 8'h00, 32'h0000_0007);

        // hit_valid gating on ch2 and channel isolation from ch3
        hit_vec[2*SLICES +: SLICES] = 32'hFFFF_FFFF;
        hit_valid = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("gate_ch2", 32'({Electron[2], Pion[2], Muon[2], Ambig[2]}), 32'h0);
        end
        clear_hits();
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < 3; k++) snap[c][k] = 32'(m_cnt[c][k]);
        for (int i = 0; i < 4; i++) begin
            set_hit(3, 32'h0000_2000);
            tick();
            clear_hits();
            tick();
        end
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < 3; k++)
                bus_read_chk("iso_cnt", 8'(64 + 4*c + k), snap[c][k]);
        bus_read_chk("iso_ch3_e", 8'h4C, 32'h4);

        // Synchronous reset in the middle of an S=15 pulse
        bus_write(8'h00, 32'h0000_00F7);
        set_hit(0, 32'h1);
        tick();
        clear_hits();
        tick();
        for (int i = 0; i < 3; i++) tick();
        check_val("hold_e", 32'(Electron[0]), 32'h1);
        rst = 1'b0;
        tick();
        check_val("rst_kill_e", 32'(Electron[0]), 32'h0);
        rst = 1'b1;
        bus_read_chk("rst_cfg_again", 8'h00, 32'h0000_0007);

        // Randomized configuration and traffic against the model
        for (int round = 0; round < 8; round++) begin
            for (int c = 0; c < NCH; c++) begin
                r = $urandom;
                bus_write(8'(4*c), {23'h0, r[8] & r[9], r[12] ? r[7:4] : {2'b00, r[5:4]}, r[3:0]});
                for (int k = 0; k < 3; k++) bus_write(8'(4*c + 1 + k), $urandom);
            end
            for (int i = 0; i < 60; i++) begin
                for (int c = 0; c < NCH; c++) begin
                    r = $urandom;
                    hit_valid[c] = r[0] | r[1];
                    if (r[3:2] == 2'd0) hit_vec[c*SLICES +: SLICES] = 32'h0;
                    else if (r[3:2] == 2'd3) hit_vec[c*SLICES +: SLICES] = $urandom;
                    else hit_vec[c*SLICES +: SLICES] = 32'h1 << r[8:4];
                end
                r = $urandom;
                if (r[3:0] == 4'd0) begin
                    ch = int'(r[5:4]);
                    Address = 8'(4*ch);
                    DataIn  = {23'h0, r[6], 4'h0, r[10:7]};
                    Write   = 1'b1;
                end
                tick();
                Write   = 1'b0;
                DataIn  = 32'h0;
                Address = 8'h00;
            end
            clear_hits();
            for (int i = 0; i < 20; i++) tick();
            for (int c = 0; c < NCH; c++)
                for (int k = 0; k < 3; k++)
                    bus_read_chk("rnd_cnt", 8'(64 + 4*c + k), model_read(8'(64 + 4*c + k)));
        end
        for (int a = 0; a < 4*NCH; a++)
            bus_read_chk("rnd_reg", 8'(a), model_read(8'(a)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pid_window_classifier.md
Name: pid_window_classifier

Overview:
- Multi-channel successor to the single-channel fine-time PID stage.
- Per channel, takes an already-decoded leading-edge time-slice vector, one per 50 MHz period, and matches it against programmable electron/pion/muon windows.
- Adds per-channel exclusive-mode ambiguity handling, output pulse stretch with retrigger inhibit, and saturating per-species hit counters.
- Sits between the per-channel fine-time decoders and the trigger logic; configured and read over the local bus.

Parameters:
- NCH, 4, number of channels (1..8).
- SLICES, 32, time slices per clock period (window and hit vector width, ≤32).
- BASE, 8'h00, local-bus base address.
- CNT_W, 16, counter width (≤32).

Ports:
- clk  in  1  50 MHz clock, sole clock.
- rst  in  1  synchronous, active-low reset.
- hit_vec  in  NCH*SLICES  decoded slice hits; channel c occupies bits [c*SLICES +: SLICES].
- hit_valid  in  NCH  per-channel qualifier for hit_vec this cycle.
- Electron  out  NCH  per-channel electron trigger pulse.
- Pion  out  NCH  per-channel pion trigger pulse.
- Muon  out  NCH  per-channel muon trigger pulse.
- Ambig  out  NCH  multiple species matched while exclusive mode is on.
- DataIn  in  32  local-bus write data.
- Address  in  8  local-bus address.
- Read  in  1  read strobe.
- Write  in  1  write strobe.
- DataOut  out  32  read data; 0 when not addressed (OR-bus).

Behaviour:
- Reset (rst=0 at a clk edge):
  - All outputs 0; counters 0; stretch/inhibit counters 0.
  - CFG=32'h0000_0007, EW=32'hFFFF_FFFF, PW=32'h0000_F000, MW=32'h0F00_0000.
  - Reset mid-pulse kills the pulse on the next edge.
- Register map, per channel c:
  - BASE+4c+0 is CFG; +1 is EW; +2 is PW; +3 is MW. All are read/write.
  - BASE+8'h40+4c+{0,1,2} are the electron, pion and muon counters. They are read-only and zero-extended to 32 bits.
  - +3 in the counter block reads 0.
- Local-bus write:
  - Takes effect at the clk edge where Write=1 and Address matches.
  - Window registers above bit SLICES-1 are ignored.
- Local-bus read:
  - DataOut is combinational while Read=1 and Address matches; otherwise 0.
- CFG bits:
  - [0] electron enable; [1] pion enable; [2] muon enable.
  - [3] exclusive mode.
  - [7:4] stretch S: pulse width is S+1 cycles.
  - [8] counter clear: write 1 clears that channel's three counters. The bit self-clears the next cycle and always reads 0.
- Pipeline:
  - Stage 1 (edge n+1): mX = hit_valid & |(hit_vec_c & XW), for X in {E,P,M}, registered.
  - Stage 2 (edge n+2): outputs and counters update.
  - Total latency is 2 cycles from a hit_vec sample to the output rising.
- Window changes:
  - A window write at edge k applies to hit_vec sampled at edge k+1 or later.
- Qualification, per species X:
  - fire_X = mX & CFG[en_X] & ~inhibit.
  - Exclusive mode with two or more enabled species matching: no species fires. Ambig pulses for 1 cycle and no counter increments.
  - Non-exclusive mode: every matching enabled species fires.
  - A disabled species neither fires nor counts.
- Per-channel stretch FSM, states IDLE and HOLD:
  - IDLE to HOLD on any fire. The fired outputs latch high and the cnt loads S.
  - In HOLD, the cnt decrements each cycle and the outputs are held.
  - HOLD returns to IDLE when cnt=0 and the cycle ends. Outputs drop on the following edge.
  - inhibit=1 in HOLD: new matches are neither output nor counted.
  - With S=0 the pulse is exactly 1 cycle and back-to-back hits produce back-to-back pulses.
- Counters:
  - +1 per fire of that species. Saturate at 2^CNT_W-1 and do not wrap.
  - A clear coinciding with an increment: the clear wins.
- Channels are fully independent.

Decomposition:
- Package pid_pkg:
  - Address offsets REG_CFG=0, REG_EW=1, REG_PW=2, REG_MW=3, CNT_BLK=8'h40.
  - CFG bit positions EN_E=0, EN_P=1, EN_M=2, EXCL=3, STR_LSB=4, STR_MSB=7, CLR=8.
  - FSM state enum {IDLE, HOLD}.
- Sub-module pid_chan:
  - One channel: its 4 registers, match pipeline, FSM and 3 counters, plus its own DataOut slice.
  - The top generates NCH instances and ORs their DataOut.

Test Plan:
- Reset defaults: after reset, on ch0 drive hit_vec bit 13 with hit_valid=1.
  - Response: at n+2, Electron[0]=1 and Pion[0]=1 for 1 cycle, Muon[0]=0.
  - Read BASE+0 returns 32'h7 and BASE+2 returns 32'hF000.
- Exclusive mode: write CFG=32'hF on ch1, then drive ch1 bit 13.
  - Response: Ambig[1]=1 for 1 cycle, Electron=Pion=0, counters stay 0.
  - Then bit 26 (MW only after EW=32'h0) gives Muon[1]=1 and the muon counter reads 1.
- Stretch and inhibit: write CFG=32'h37 (S=3) and EW=32'h1, then hit bit 0 at cycles 0 and 2.
  - Response: Electron high cycles 2..5; electron count = 1.
- Saturation and clear: CNT_W=4; drive 20 electron hits spaced 2 cycles apart with S=0.
  - Response: counter reads 15. Write CFG with bit 8 set: it reads 0 next cycle and CFG bit 8 reads 0.
- hit_valid gating and channel isolation: hit_vec all-ones on ch2 with hit_valid=0.
  - Response: no outputs.
  - Ch3 hits give ch0..2 counters unchanged.
- Synchronous reset mid-HOLD with S=15: deassert rst for 1 cycle at cycle 4 of the pulse.
  - Response: Electron=0 on the next edge; CFG reads 32'h7.
